// File: rtl/motor_pkg.sv
// Shared constants, types and helpers for the ramped signed-power motor driver.
package motor_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_BWD  = 2'b10;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_DEAD
  } chan_state_t;

  // 100 MHz clock, 50 kHz PWM
  localparam int unsigned DEFAULT_PERIOD = 2000;
  localparam int unsigned DEFAULT_OFFSET = 400;

  // Swaps forward/backward for channels wired to the bridge the other way round.
  function automatic logic [1:0] dir_apply_invert(input logic [1:0] d, input logic inv);
    return inv ? {d[0], d[1]} : d;
  endfunction

endpackage

// File: rtl/motor_ramp_channel.sv
// One motor channel: target derivation, STOP/RUN/DEAD FSM, slew limiter and PWM threshold latch.
module motor_ramp_channel
  import motor_pkg::*;
#(
  parameter int unsigned PWR_W        = 16,
  parameter int unsigned DUTY_W       = 10,
  parameter int unsigned PERIOD       = DEFAULT_PERIOD,
  parameter int unsigned OFFSET       = DEFAULT_OFFSET,
  parameter int unsigned RAMP_STEP    = 8,
  parameter int unsigned DEAD_PERIODS = 4,
  parameter int unsigned CNT_W        = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              boundary,
  input  logic [PWR_W-1:0]  power,
  output logic [DUTY_W-1:0] duty,
  output logic [1:0]        dir,
  output logic [CNT_W-1:0]  threshold_next
);

  localparam int unsigned MAG_W  = PWR_W + 1;
  localparam int unsigned SUM_W  = ((MAG_W > 32) ? MAG_W : 32) + 1;
  localparam int unsigned PROD_W = DUTY_W + CNT_W + 1;
  localparam int unsigned DC_W   = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

  localparam logic [DUTY_W-1:0] FULL      = {DUTY_W{1'b1}};
  localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);
  localparam logic [DC_W-1:0]   DEAD_LAST = DC_W'(DEAD_PERIODS - 1);

  logic [MAG_W-1:0]  pwr_ext;
  logic [MAG_W-1:0]  mag;
  logic [SUM_W-1:0]  sum;
  logic [DUTY_W-1:0] tgt_duty;
  logic [1:0]        tgt_dir;

  chan_state_t       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [1:0]        dir_q, dir_d;
  logic [DC_W-1:0]   dead_q, dead_d;
  logic [CNT_W-1:0]  thr_q, thr_d;
  logic [PROD_W-1:0] prod;

  // One extra bit so the most-negative setpoint has a representable magnitude.
  assign pwr_ext = {power[PWR_W-1], power};
  assign mag     = power[PWR_W-1] ? (~pwr_ext + MAG_W'(1)) : pwr_ext;
  assign sum     = SUM_W'(mag) + SUM_W'(OFFSET);

  always_comb begin
    tgt_duty = '0;
    tgt_dir  = DIR_STOP;
    if (mag != '0) begin
      tgt_duty = (sum > SUM_W'(FULL)) ? FULL : sum[DUTY_W-1:0];
      tgt_dir  = power[PWR_W-1] ? DIR_BWD : DIR_FWD;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    if (!enable) begin
      state_d = ST_STOP;
      duty_d  = '0;
      dir_d   = DIR_STOP;
      dead_d  = '0;
    end else if (boundary) begin
      unique case (state_q)
        ST_STOP: begin
          duty_d = '0;
          dir_d  = DIR_STOP;
          if (tgt_duty != '0) begin
            dir_d   = tgt_dir;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if ((tgt_duty != '0) && (tgt_dir == dir_q)) begin
            if (tgt_duty > duty_q) begin
              duty_d = ((tgt_duty - duty_q) > STEP) ? (duty_q + STEP) : tgt_duty;
            end else begin
              duty_d = ((duty_q - tgt_duty) > STEP) ? (duty_q - STEP) : tgt_duty;
            end
          end else if (duty_q <= STEP) begin
            duty_d = '0;
            dir_d  = DIR_STOP;
            if (tgt_duty == '0) begin
              state_d = ST_STOP;
            end else begin
              state_d = ST_DEAD;
              dead_d  = '0;
            end
          end else begin
            duty_d = duty_q - STEP;
          end
        end
        ST_DEAD: begin
          duty_d = '0;
          dir_d  = DIR_STOP;
          // Target is only re-read on exit, so the full dead time always elapses.
          if (dead_q == DEAD_LAST) begin
            if (tgt_duty != '0) begin
              state_d = ST_RUN;
              dir_d   = tgt_dir;
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            dead_d = dead_q + DC_W'(1);
          end
        end
        default: begin
          state_d = ST_STOP;
          duty_d  = '0;
          dir_d   = DIR_STOP;
        end
      endcase
    end
  end

  assign prod = PROD_W'(duty_d) * PROD_W'(PERIOD);

  always_comb begin
    thr_d = thr_q;
    if (!enable) begin
      thr_d = '0;
    end else if (boundary) begin
      thr_d = CNT_W'(prod >> DUTY_W);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOP;
      duty_q  <= '0;
      dir_q   <= DIR_STOP;
      dead_q  <= '0;
      thr_q   <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      thr_q   <= thr_d;
    end
  end

  assign duty           = duty_q;
  assign dir            = dir_q;
  assign threshold_next = thr_d;

endmodule

// File: rtl/motor_driver_ramp.sv
// N-channel ramped H-bridge driver: shared PWM period counter, enable gating and PWM compare.
module motor_driver_ramp
  import motor_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned PWR_W        = 16,
  parameter int unsigned DUTY_W       = 10,
  parameter int unsigned PERIOD       = DEFAULT_PERIOD,
  parameter int unsigned OFFSET       = DEFAULT_OFFSET,
  parameter int unsigned RAMP_STEP    = 8,
  parameter int unsigned DEAD_PERIODS = 4,
  parameter logic [CHANNELS-1:0] DIR_INVERT = {CHANNELS{1'b0}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [CHANNELS*PWR_W-1:0]  power,
  output logic [CHANNELS-1:0]        pwm_out,
  output logic [2*CHANNELS-1:0]      dir,
  output logic [CHANNELS*DUTY_W-1:0] duty_dbg,
  output logic                       period_tick
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_next;
  logic                boundary;
  logic [CHANNELS-1:0] pwm_d;
  logic [CHANNELS-1:0] pwm_q;

  assign boundary    = (cnt_q == CNT_LAST);
  assign cnt_next    = boundary ? '0 : (cnt_q + CNT_W'(1));
  assign period_tick = boundary;

  // Counter is free-running; enable only gates the channels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_next;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [1:0]       ch_dir;
    logic [CNT_W-1:0] ch_thr;

    motor_ramp_channel #(
      .PWR_W        (PWR_W),
      .DUTY_W       (DUTY_W),
      .PERIOD       (PERIOD),
      .OFFSET       (OFFSET),
      .RAMP_STEP    (RAMP_STEP),
      .DEAD_PERIODS (DEAD_PERIODS),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .boundary       (boundary),
      .power          (power[g*PWR_W +: PWR_W]),
      .duty           (duty_dbg[g*DUTY_W +: DUTY_W]),
      .dir            (ch_dir),
      .threshold_next (ch_thr)
    );

    assign dir[2*g +: 2] = dir_apply_invert(ch_dir, DIR_INVERT[g]);
    // Compare against the upcoming count so a new threshold applies from cycle 0.
    assign pwm_d[g] = enable & (cnt_next < ch_thr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_motor_driver_ramp.sv
// Self-checking bench for motor_driver_ramp: per-cycle model compare plus directed literal checks.
module tb_motor_driver_ramp;

  localparam int P    = 50;
  localparam int OFF  = 400;
  localparam int STEP = 8;
  localparam int DEAD = 4;
  localparam int FS   = 1023;

  logic               clk;
  logic               reset;
  logic               enable;
  logic signed [15:0] pw [2];
  logic [31:0]        power;
  logic [1:0]         pwm_out;
  logic [3:0]         dir;
  logic [19:0]        duty_dbg;
  logic               period_tick;

  assign power = {pw[1], pw[0]};

  motor_driver_ramp #(
    .CHANNELS     (2),
    .PWR_W        (16),
    .DUTY_W       (10),
    .PERIOD       (P),
    .OFFSET       (OFF),
    .RAMP_STEP    (STEP),
    .DEAD_PERIODS (DEAD),
    .DIR_INVERT   (2'b10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .power       (power),
    .pwm_out     (pwm_out),
    .dir         (dir),
    .duty_dbg    (duty_dbg),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Model: mode 0 stop, 1 run, 2 dead; sgn is the drive direction as +1/-1/0.
  typedef struct {
    int mode;
    int duty;
    int sgn;
    int dc;
  } chan_t;

  chan_t m_ch [2];
  int    m_thr [2];
  bit    m_pwm [2];
  int    m_cnt;

  function automatic chan_t next_chan(chan_t c, int p);
    chan_t n;
    int mag, t, s;
    n   = c;
    mag = (p < 0) ? -p : p;
    t   = (mag == 0) ? 0 : ((mag + OFF > FS) ? FS : mag + OFF);
    s   = (p > 0) ? 1 : ((p < 0) ? -1 : 0);
    case (c.mode)
      0: if (t != 0) begin n.mode = 1; n.sgn = s; end
      1: begin
        if (t != 0 && s == c.sgn) begin
          if (t - c.duty > STEP)      n.duty = c.duty + STEP;
          else if (c.duty - t > STEP) n.duty = c.duty - STEP;
          else                        n.duty = t;
        end else if (c.duty <= STEP) begin
          n.duty = 0;
          n.sgn  = 0;
          n.mode = (t == 0) ? 0 : 2;
          n.dc   = 0;
        end else begin
          n.duty = c.duty - STEP;
        end
      end
      default: begin
        if (c.dc == DEAD - 1) begin
          n.mode = (t == 0) ? 0 : 1;
          n.sgn  = (t == 0) ? 0 : s;
        end else begin
          n.dc = c.dc + 1;
        end
      end
    endcase
    return n;
  endfunction

  function automatic logic [1:0] dcode(int sgn, bit inv);
    if (sgn == 0) return 2'b00;
    return ((sgn > 0) ^ inv) ? 2'b01 : 2'b10;
  endfunction

  always @(posedge clk or posedge reset) begin
    chan_t nc;
    int    thr;
    bit    bnd;
    int    nxt;
    if (reset) begin
      m_cnt <= 0;
      for (int ch = 0; ch < 2; ch++) begin
        m_ch[ch]  <= '{0, 0, 0, 0};
        m_thr[ch] <= 0;
        m_pwm[ch] <= 1'b0;
      end
    end else begin
      bnd = (m_cnt == P - 1);
      nxt = bnd ? 0 : m_cnt + 1;
      for (int ch = 0; ch < 2; ch++) begin
        nc  = m_ch[ch];
        thr = m_thr[ch];
        if (!enable) begin
          nc  = '{0, 0, 0, 0};
          thr = 0;
        end else if (bnd) begin
          nc  = next_chan(m_ch[ch], int'(pw[ch]));
          thr = (nc.duty * P) / 1024;
        end
        m_ch[ch]  <= nc;
        m_thr[ch] <= thr;
        m_pwm[ch] <= enable && (nxt < thr);
      end
      m_cnt <= nxt;
    end
  end

  always @(negedge clk) begin
    logic [26:0] exp_v;
    logic [26:0] got_v;
    if (chk_on) begin
      exp_v = {m_pwm[1], m_pwm[0], dcode(m_ch[1].sgn, 1'b1), dcode(m_ch[0].sgn, 1'b0),
               10'(m_ch[1].duty), 10'(m_ch[0].duty), (m_cnt == P - 1)};
      got_v = {pwm_out, dir, duty_dbg, period_tick};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_periods(input int n);
    wait_cycles(n * P);
  endtask

  task automatic to_period_start();
    int b;
    b = 0;
    @(negedge clk);
    while (m_cnt != 0 && b < P + 2) begin
      @(negedge clk);
      b++;
    end
    check("period_align", m_cnt, 0);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n * P; k++) begin
      if (pwm_out[ch]) hi++;
      @(negedge clk);
    end
  endtask

  function automatic int duty_of(input int ch);
    return (ch == 0) ? int'(duty_dbg[9:0]) : int'(duty_dbg[19:10]);
  endfunction

  function automatic int dir_of(input int ch);
    return (ch == 0) ? int'(dir[1:0]) : int'(dir[3:2]);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t bench did not complete", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    reset  = 1'b0;
    enable = 1'b0;
    pw[0]  = '0;
    pw[1]  = '0;
    #1 reset = 1'b1;
    #2 check("reset_state", int'({pwm_out, dir, duty_dbg, period_tick}), 0);
    wait_cycles(3);
    reset  = 1'b0;
    enable = 1'b1;
    chk_on = 1'b1;
    to_period_start();

    // Ramp-up from STOP
    pw[0] = 16'sd100;
    wait_periods(1);
    check("rampup_dir", dir_of(0), 1);
    check("rampup_duty0", duty_of(0), 0);
    wait_periods(1);
    check("rampup_first_step", duty_of(0), 8);
    wait_periods(61);
    check("rampup_496", duty_of(0), 496);
    wait_periods(1);
    check("rampup_500", duty_of(0), 500);
    count_high(0, 1, hi);
    check("pwm_high_500", hi, 24);

    // Zero setpoint: ramp down into STOP, no dead time
    pw[0] = 16'sd0;
    wait_periods(62);
    check("zero_duty4", duty_of(0), 4);
    wait_periods(1);
    check("zero_duty0", duty_of(0), 0);
    check("zero_dir", dir_of(0), 0);
    pw[0] = 16'sd100;
    wait_periods(1);
    check("zero_restart_dir", dir_of(0), 1);
    wait_periods(63);
    check("zero_reramp_500", duty_of(0), 500);

    // Reversal with dead interval
    pw[0] = -16'sd100;
    wait_periods(62);
    check("rev_duty4", duty_of(0), 4);
    check("rev_dir_fwd", dir_of(0), 1);
    wait_periods(1);
    check("rev_dead_dir", dir_of(0), 0);
    count_high(0, 3, hi);
    check("rev_dead_pwm", hi, 0);
    check("rev_dead_last_dir", dir_of(0), 0);
    wait_periods(1);
    check("rev_bwd_dir", dir_of(0), 2);
    check("rev_bwd_duty0", duty_of(0), 0);
    wait_periods(63);
    check("rev_bwd_500", duty_of(0), 500);

    // Saturation with the most-negative setpoint
    pw[0] = 16'sh8000;
    wait_periods(65);
    check("sat_1020", duty_of(0), 1020);
    wait_periods(1);
    check("sat_1023", duty_of(0), 1023);
    check("sat_dir", dir_of(0), 2);
    count_high(0, 1, hi);
    check("pwm_high_1023", hi, 49);

    // Emergency stop mid-ramp
    pw[0] = 16'sd100;
    wait_periods(5);
    check("estop_pre_duty", duty_of(0), 983);
    wait_cycles(20);
    enable = 1'b0;
    @(negedge clk);
    check("estop_pwm", int'(pwm_out), 0);
    check("estop_dir", int'(dir), 0);
    check("estop_duty", int'(duty_dbg), 0);
    wait_periods(2);
    to_period_start();
    enable = 1'b1;
    wait_periods(1);
    check("reenable_dir", dir_of(0), 1);
    check("reenable_duty0", duty_of(0), 0);
    wait_periods(1);
    check("reenable_duty8", duty_of(0), 8);

    // Enable falling on the boundary cycle beats the boundary update
    wait_cycles(P - 1);
    enable = 1'b0;
    @(negedge clk);
    check("bnd_estop_duty", duty_of(0), 0);
    check("bnd_estop_dir", dir_of(0), 0);
    wait_cycles(3);
    enable = 1'b1;

    // Async reset mid-period, then two independent channels
    wait_cycles(7);
    #2 reset = 1'b1;
    #1 check("async_reset", int'({pwm_out, dir, duty_dbg, period_tick}), 0);
    pw[0] = 16'sd1000;
    pw[1] = -16'sd300;
    wait_cycles(3);
    reset = 1'b0;
    to_period_start();
    check("indep_dir0", dir_of(0), 1);
    check("indep_dir1_inv", dir_of(1), 1);
    wait_periods(88);
    check("indep_ch1_700", duty_of(1), 700);
    check("indep_ch0_704", duty_of(0), 704);
    wait_periods(40);
    check("indep_ch0_1023", duty_of(0), 1023);
    check("indep_ch1_hold", duty_of(1), 700);
    count_high(1, 1, hi);
    check("pwm_high_700", hi, 34);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_driver_ramp.md
Name: motor_driver_ramp

Overview:
N-channel signed-power motor driver. It is the successor to the single-setpoint, two-PWM motor block, and it sits between the control loop and the H-bridge pmod pins.
Per channel it adds a deadband offset, saturation, slew-rate limiting, and a dead interval before any direction reversal. All channels run from one shared PWM period counter and update only on period boundaries, so PWM output is glitch-free.

Parameters:
CHANNELS, 2, number of independent motor channels
PWR_W, 16, width of each signed power input (two's complement)
DUTY_W, 10, duty resolution; full scale is 2^DUTY_W-1
PERIOD, 2000, clk cycles per PWM period (100 MHz / 50 kHz)
OFFSET, 400, deadband offset added to every nonzero magnitude
RAMP_STEP, 8, maximum duty change per PWM period
DEAD_PERIODS, 4, zero-drive PWM periods inserted on reversal
DIR_INVERT, {CHANNELS{1'b0}}, per-channel bit that swaps the forward/backward encoding

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  global drive enable; low = emergency stop
power  in  CHANNELS*PWR_W  signed setpoint; channel i is power[i*PWR_W +: PWR_W]
pwm_out  out  CHANNELS  registered PWM, one bit per channel
dir  out  2*CHANNELS  per channel: 00 stop, 01 forward, 10 backward (before DIR_INVERT)
duty_dbg  out  CHANNELS*DUTY_W  current ramped duty per channel
period_tick  out  1  one-cycle pulse when the counter is at PERIOD-1

Behaviour:
- Reset (asynchronous): counter=0; every channel state=STOP, duty=0, threshold=0; pwm_out=0, dir=00, period_tick=0.
- Counter runs 0..PERIOD-1 and wraps. Boundary = the cycle where counter==PERIOD-1.
- Target, combinational per channel:
  - mag=|power|, computed in PWR_W+1 bits. The most-negative input gives 2^(PWR_W-1).
  - tgt_duty = 0 if mag==0, else min(mag+OFFSET, 2^DUTY_W-1). The sum is computed without truncation.
  - tgt_dir = 01 if power>0, 10 if power<0.
- Per-channel FSM. State and duty change only at boundaries.
- STOP: duty=0, dir=00. If tgt_duty!=0: dir<=tgt_dir, go to RUN.
- RUN, target in the same direction and nonzero: duty moves toward tgt_duty by min(RAMP_STEP, |difference|).
- RUN, target zero or opposite direction: duty ramps down. If duty<=RAMP_STEP, duty<=0, then:
  - target zero -> STOP (dir<=00);
  - target opposite -> DEAD (dir<=00, dead_cnt<=0).
- DEAD: duty=0, dir=00, dead_cnt increments each boundary. When dead_cnt==DEAD_PERIODS-1 at a boundary:
  - target nonzero -> RUN with dir<=tgt_dir;
  - target zero -> STOP.
  - The target is re-read at exit, so a setpoint that flips back during DEAD still completes the full dead time.
- Threshold: at each boundary, latch threshold = (new_duty*PERIOD)>>DUTY_W. Use a full-width product; no overflow is allowed.
- PWM: pwm_out <= (next counter value < threshold), registered. A new duty takes effect from the first cycle of the next period. Duty 0 gives a constant 0.
- Latency: power sampled at boundary k -> dir/duty_dbg updated at the first cycle of period k+1 -> pwm_out follows on the same cycle (registered from the next count).
- enable low: on the next clk edge, not waiting for a boundary, all channels go STOP with duty=0, threshold=0, pwm_out=0, dir=00. The counter keeps running. When enable is re-asserted, ramps start from 0 at the next boundary.
- Boundary that coincides with enable falling: enable wins.
- Target changes mid-period are ignored until the boundary.
- Reset mid-operation: immediate return to reset values. The first boundary is PERIOD cycles after release.
- DIR_INVERT[i]=1: dir[i] swaps the 01/10 encoding. 00 is unaffected.

Decomposition:
- Shared package motor_pkg:
  - DIR_STOP=2'b00, DIR_FWD=2'b01, DIR_BWD=2'b10;
  - channel state enum {ST_STOP, ST_RUN, ST_DEAD};
  - default PERIOD and OFFSET constants.
- Sub-module motor_ramp_channel holds one channel's FSM, ramp, dead counter and threshold latch. It is instantiated CHANNELS times with a generate loop.
- The top level owns the counter, period_tick, enable gating and PWM compare.

Test Plan:
All scenarios use the defaults (PERIOD=2000, OFFSET=400, RAMP_STEP=8, DEAD_PERIODS=4, DUTY_W=10).
1. Ramp-up: ch0 power=+100 from STOP.
   - dir=01 after the first boundary.
   - duty_dbg steps 8,16,...,496, then 500 on step 63.
   - At duty 500, pwm_out high for 976 cycles/period.
2. Saturation: power=+1000 -> duty ramps to a ceiling of 1023, threshold 1998. power=16'h8000 -> dir=10, target 1023.
3. Reversal: +100 at steady 500, then -100.
   - Ramp down 500..0 over 63 periods.
   - Then exactly 4 periods of dir=00 with pwm_out=0.
   - Then dir=10 and ramp up to 500.
4. Zero setpoint: steady +100, then 0 -> ramp down to 0, STOP, dir=00, no DEAD periods.
5. Emergency stop: enable deasserted mid-period during a ramp.
   - Next cycle: pwm_out=0, dir=00, duty_dbg=0.
   - Re-enable -> ramp restarts from 8.
6. Reset and independence:
   - Async reset asserted mid-period -> all outputs 0 with no clock edge.
   - Two channels (+100 / -300, DIR_INVERT=2'b10) ramp independently; ch1 shows dir=01.
